// File: rtl/case_mul_pipe_sat.sv
// ---------------------------------------------------------------------------
// case_mul_pipe_sat
//
// Pipelined integer multiplier with valid/ready flow control. The full-width
// product is optionally rounded, right-shifted and then either clamped or
// wrapped to the result width. An overflow flag travels with each result.
// Results leave in issue order. The whole pipeline advances together and
// stalls as one unit when the output is held.
//
// Ports
//   ap_clk     in   clock, rising edge
//   ap_rst_n   in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  block can accept this cycle (= global advance enable)
//   din0       in   operand 0 [din0_WIDTH]
//   din1       in   operand 1 [din1_WIDTH]
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   dout       out  scaled, saturated or wrapped product [dout_WIDTH]
//   ovf        out  result not representable in dout_WIDTH (with out_valid)
//   occupancy  out  number of valid entries held in the pipeline
// ---------------------------------------------------------------------------
module case_mul_pipe_sat #(
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26,
  parameter int NUM_STAGE  = 3,
  parameter int SIGNED     = 1,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0,
  parameter int SAT        = 1
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [din0_WIDTH-1:0]            din0,
  input  logic [din1_WIDTH-1:0]            din1,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [dout_WIDTH-1:0]            dout,
  output logic                             ovf,
  output logic [$clog2(NUM_STAGE+1)-1:0]   occupancy
);

  // Full product width.
  localparam int W   = din0_WIDTH + din1_WIDTH;
  // Working width: wide enough for the rounding add (W+1) and always at least
  // one bit wider than the result, so the range check has a guard bit.
  localparam int EW  = ((W + 1) > (dout_WIDTH + 1)) ? (W + 1) : (dout_WIDTH + 1);
  localparam int OCW = $clog2(NUM_STAGE + 1);
  // Rounding bit position; clamped so the shift amount is never negative.
  localparam int RSH = (SHIFT > 0) ? (SHIFT - 1) : 0;
  localparam bit DO_ROUND = (ROUND != 0) && (SHIFT > 0);

  // Multiply, round, shift and range-limit one operand pair.
  // Returns {ovf, dout}.
  function automatic logic [dout_WIDTH:0] scale_sat(
    input logic [din0_WIDTH-1:0] a,
    input logic [din1_WIDTH-1:0] b
  );
    logic [W-1:0]          ax;
    logic [W-1:0]          bx;
    logic [W-1:0]          p;
    logic [EW-1:0]         pe;
    logic [EW-1:0]         rc;
    logic [EW-1:0]         rs;
    logic                  ovf_v;
    logic [dout_WIDTH-1:0] d;
    // Extending both operands to W bits makes the W-bit truncated product
    // exact: the true product (including most-negative squared) fits in W bits.
    if (SIGNED != 0) begin
      ax = {{din1_WIDTH{a[din0_WIDTH-1]}}, a};
      bx = {{din0_WIDTH{b[din1_WIDTH-1]}}, b};
    end else begin
      ax = {{din1_WIDTH{1'b0}}, a};
      bx = {{din0_WIDTH{1'b0}}, b};
    end
    p = ax * bx;
    if (SIGNED != 0) begin
      pe = {{(EW-W){p[W-1]}}, p};
    end else begin
      pe = {{(EW-W){1'b0}}, p};
    end
    if (DO_ROUND) begin
      rc = {{(EW-1){1'b0}}, 1'b1} << RSH;
    end else begin
      rc = {EW{1'b0}};
    end
    pe = pe + rc;
    if (SIGNED != 0) begin
      rs = $signed(pe) >>> SHIFT;
    end else begin
      rs = pe >> SHIFT;
    end
    // Out of range when any bit above the result field disagrees with the
    // sign (signed) or is set at all (unsigned).
    ovf_v = 1'b0;
    if (SIGNED != 0) begin
      for (int i = dout_WIDTH - 1; i < EW; i++) begin
        if (rs[i] != rs[EW-1]) begin
          ovf_v = 1'b1;
        end else begin
          ovf_v = ovf_v;
        end
      end
    end else begin
      for (int i = dout_WIDTH; i < EW; i++) begin
        if (rs[i]) begin
          ovf_v = 1'b1;
        end else begin
          ovf_v = ovf_v;
        end
      end
    end
    if (ovf_v && (SAT != 0)) begin
      if (SIGNED != 0) begin
        if (rs[EW-1]) begin
          d = {1'b1, {(dout_WIDTH-1){1'b0}}};
        end else begin
          d = {1'b0, {(dout_WIDTH-1){1'b1}}};
        end
      end else begin
        // Unsigned results can only leave the range upwards.
        d = {dout_WIDTH{1'b1}};
      end
    end else begin
      d = rs[dout_WIDTH-1:0];
    end
    return {ovf_v, d};
  endfunction

  logic                  en_s;
  logic                  in_xfer_s;
  logic                  out_xfer_s;
  logic [dout_WIDTH:0]   res_s;
  logic [NUM_STAGE-1:0]  vld_q;
  logic [NUM_STAGE-1:0]  ovf_q;
  logic [dout_WIDTH-1:0] dat_q [NUM_STAGE];
  logic [OCW-1:0]        occ_q;
  logic [OCW-1:0]        occ_d;

  // Arithmetic sits in front of stage 1; later stages only carry the result.
  always_comb begin
    res_s = scale_sat(din0, din1);
  end

  // Global advance: the pipeline moves whenever the output slot is free or
  // being drained this cycle.
  always_comb begin
    en_s       = ~vld_q[NUM_STAGE-1] | out_ready;
    in_xfer_s  = in_valid & en_s;
    out_xfer_s = vld_q[NUM_STAGE-1] & out_ready;
  end

  // Occupancy next state from the two transfer events.
  always_comb begin
    occ_d = occ_q;
    case ({in_xfer_s, out_xfer_s})
      2'b10:   occ_d = occ_q + OCW'(1'b1);
      2'b01:   occ_d = occ_q - OCW'(1'b1);
      default: occ_d = occ_q;
    endcase
  end

  // Stage registers: valid bits, results and overflow flags shift together.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q <= {NUM_STAGE{1'b0}};
      ovf_q <= {NUM_STAGE{1'b0}};
      for (int i = 0; i < NUM_STAGE; i++) begin
        dat_q[i] <= {dout_WIDTH{1'b0}};
      end
    end else if (en_s) begin
      for (int i = NUM_STAGE - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        ovf_q[i] <= ovf_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
      vld_q[0] <= in_valid;
      ovf_q[0] <= res_s[dout_WIDTH];
      dat_q[0] <= res_s[dout_WIDTH-1:0];
    end else begin
      vld_q <= vld_q;
      ovf_q <= ovf_q;
    end
  end

  // Occupancy counter register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      occ_q <= {OCW{1'b0}};
    end else begin
      occ_q <= occ_d;
    end
  end

  assign in_ready  = en_s;
  assign out_valid = vld_q[NUM_STAGE-1];
  assign dout      = dat_q[NUM_STAGE-1];
  assign ovf       = ovf_q[NUM_STAGE-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_case_mul_pipe_sat.sv
// ---------------------------------------------------------------------------
// tb_case_mul_pipe_sat
//
// Three instances share the operand/handshake inputs:
//   u_a : default configuration (26-bit signed result, no scaling, saturate)
//   u_b : 8-bit result, shift 4 with rounding, saturate
//   u_c : 8-bit result, shift 4 with rounding, wrap
// Expected results come from a longint reference model and are queued on
// every input transfer; they are popped and compared on every output transfer.
// ---------------------------------------------------------------------------
module tb_case_mul_pipe_sat;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [13:0] din0;
  logic [11:0] din1;

  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [25:0] dout_a;
  logic [7:0]  dout_b, dout_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [1:0]  occupancy_a, occupancy_b, occupancy_c;

  case_mul_pipe_sat u_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .din0(din0), .din1(din1), .out_valid(out_valid_a), .out_ready(out_ready),
    .dout(dout_a), .ovf(ovf_a), .occupancy(occupancy_a)
  );

  case_mul_pipe_sat #(.dout_WIDTH(8), .SHIFT(4), .ROUND(1), .SAT(1)) u_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .din0(din0), .din1(din1), .out_valid(out_valid_b), .out_ready(out_ready),
    .dout(dout_b), .ovf(ovf_b), .occupancy(occupancy_b)
  );

  case_mul_pipe_sat #(.dout_WIDTH(8), .SHIFT(4), .ROUND(1), .SAT(0)) u_c (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .din0(din0), .din1(din1), .out_valid(out_valid_c), .out_ready(out_ready),
    .dout(dout_c), .ovf(ovf_c), .occupancy(occupancy_c)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [25:0] d0;
    logic        o0;
    logic [7:0]  d1;
    logic        o1;
    logic [7:0]  d2;
    logic        o2;
    int          acc;
    bit          lc;
  } sb_t;

  sb_t  q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cur_a = 0;
  int   cur_b = 0;
  bit   last_acc = 1'b0;
  bit   lat_chk = 1'b1;
  int   idx;
  logic [25:0] held;
  int   opa [5] = '{123, -456, 789, -1011, 4095};
  int   opb [5] = '{-7, 33, -2048, 2047, -1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact product, round-half-up, arithmetic shift, range limit.
  function automatic void model(input longint a, input longint b, input int dw, input int sh,
                                input bit rnd, input bit sat, output longint d, output bit o);
    longint p, r, lo, hi;
    p = a * b;
    if (rnd && sh > 0) p = p + (64'sd1 <<< (sh - 1));
    r  = p >>> sh;
    lo = -(64'sd1 <<< (dw - 1));
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    if (r > hi) begin
      o = 1'b1;
      d = sat ? hi : r;
    end else if (r < lo) begin
      o = 1'b1;
      d = sat ? lo : r;
    end else begin
      o = 1'b0;
      d = r;
    end
  endfunction

  task automatic push(input int a, input int b);
    sb_t    e;
    longint d;
    bit     o;
    model(a, b, 26, 0, 1'b0, 1'b1, d, o); e.d0 = d[25:0]; e.o0 = o;
    model(a, b, 8, 4, 1'b1, 1'b1, d, o);  e.d1 = d[7:0];  e.o1 = o;
    model(a, b, 8, 4, 1'b1, 1'b0, d, o);  e.d2 = d[7:0];  e.o2 = o;
    e.acc = cyc;
    e.lc  = lat_chk;
    q.push_back(e);
  endtask

  task automatic drive(input int a, input int b);
    cur_a    = a;
    cur_b    = b;
    din0     = a[13:0];
    din1     = b[11:0];
    in_valid = 1'b1;
  endtask

  // One clock: sample transfers in the low phase, then advance to next negedge.
  task automatic tick();
    sb_t e;
    #1;
    if (out_valid_a === 1'b1 && out_ready === 1'b1) begin
      chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("dout_a", 64'(dout_a), 64'(e.d0));
        chk("ovf_a", 64'(ovf_a), 64'(e.o0));
        chk("valid_b", 64'(out_valid_b), 64'd1);
        chk("dout_b_sat", 64'(dout_b), 64'(e.d1));
        chk("ovf_b_sat", 64'(ovf_b), 64'(e.o1));
        chk("valid_c", 64'(out_valid_c), 64'd1);
        chk("dout_c_wrap", 64'(dout_c), 64'(e.d2));
        chk("ovf_c_wrap", 64'(ovf_c), 64'(e.o2));
        if (e.lc) chk("latency", 64'(cyc - e.acc), 64'd3);
      end
    end
    last_acc = 1'b0;
    if (in_valid === 1'b1 && in_ready_a === 1'b1) begin
      push(cur_a, cur_b);
      last_acc = 1'b1;
    end
    @(posedge ap_clk);
    cyc++;
    @(negedge ap_clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && q.size() != 0; k++) tick();
    chk("drain_done", 64'(q.size()), 64'd0);
  endtask

  initial begin
    ap_rst_n  = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din0      = 14'd0;
    din1      = 12'd0;
    #1 ap_rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_occupancy", 64'(occupancy_a), 64'd0);
    chk("rst_dout", 64'(dout_a), 64'd0);
    chk("rst_ovf", 64'(ovf_a), 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Single beat, full-scale positive operands.
    drive(8191, 2047);
    tick();
    drain();
    #1 chk("t1_occ_zero", 64'(occupancy_a), 64'd0);

    // Rounding / saturation / wrap patterns back-to-back, plus corners.
    drive(100, 5);        tick();
    drive(-100, 5);       tick();
    drive(-8192, -2048);  tick();
    drive(8191, -2048);   tick();
    drive(-8192, 2047);   tick();
    drive(0, -2048);      tick();
    drain();

    // Stall with out_ready low: only three enter, output held stable.
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    idx       = 0;
    for (int i = 0; i < 5; i++) begin
      drive(opa[idx], opb[idx]);
      tick();
      if (last_acc) idx++;
    end
    #1;
    chk("stall_accepts", 64'(idx), 64'd3);
    chk("stall_in_ready", 64'(in_ready_a), 64'd0);
    chk("stall_in_ready_b", 64'(in_ready_b), 64'd0);
    chk("stall_in_ready_c", 64'(in_ready_c), 64'd0);
    chk("stall_occ", 64'(occupancy_a), 64'd3);
    chk("stall_occ_b", 64'(occupancy_b), 64'd3);
    chk("stall_occ_c", 64'(occupancy_c), 64'd3);
    chk("stall_out_valid", 64'(out_valid_a), 64'd1);
    held = dout_a;
    tick();
    #1;
    chk("stall_dout_stable", 64'(dout_a), 64'(held));
    chk("stall_occ_hold", 64'(occupancy_a), 64'd3);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && idx < 5; k++) begin
      drive(opa[idx], opb[idx]);
      tick();
      if (last_acc) idx++;
    end
    chk("stall_all_accepted", 64'(idx), 64'd5);
    drain();
    lat_chk = 1'b1;

    // Continuous streaming.
    for (int i = 0; i < 20; i++) begin
      drive(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 4095)) - 2048);
      #1;
      if (i >= 3) begin
        chk("stream_occ", 64'(occupancy_a), 64'd3);
        chk("stream_valid", 64'(out_valid_a), 64'd1);
      end
      tick();
    end
    drain();

    // Reset with two beats in flight.
    drive(1000, -1000); tick();
    drive(-3, 5);       tick();
    in_valid = 1'b0;
    #1 chk("pre_rst_occ", 64'(occupancy_a), 64'd2);
    #1 ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid_a), 64'd0);
    chk("mid_rst_occ", 64'(occupancy_a), 64'd0);
    chk("mid_rst_dout", 64'(dout_a), 64'd0);
    chk("mid_rst_ovf", 64'(ovf_a), 64'd0);
    #1 ap_rst_n = 1'b1;
    q.delete();
    for (int i = 0; i < 5; i++) begin
      tick();
      #1 chk("no_stale", 64'(out_valid_a), 64'd0);
    end
    drive(77, -9);
    tick();
    drain();
    #1 chk("post_rst_occ", 64'(occupancy_a), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/case_mul_pipe_sat.md
Name: case_mul_pipe_sat

Overview:
Parametrised, pipelined integer multiplier with a valid/ready handshake. It supports signed or unsigned operands, a post-multiply right shift with optional rounding, and saturation or wrap to the output width, with an overflow flag. It replaces fixed-latency combinational multiply units in generated datapaths where stalls, scaling and clamping are needed. Results leave in strict issue order.

Parameters:
din0_WIDTH, 14, width of operand din0 (2..32)
din1_WIDTH, 12, width of operand din1 (2..32)
dout_WIDTH, 26, width of result dout (2..64)
NUM_STAGE, 3, accept-to-out_valid latency in cycles (1..8)
SIGNED, 1, 1 = two's-complement operands and result; 0 = unsigned
SHIFT, 0, right shift applied to full product (0..din0_WIDTH+din1_WIDTH-1)
ROUND, 0, 1 = add 2^(SHIFT-1) before shift (round half up); ignored when SHIFT=0
SAT, 1, 1 = clamp to dout range; 0 = truncate (wrap)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept this cycle
din0  in  din0_WIDTH  operand 0
din1  in  din1_WIDTH  operand 1
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
dout  out  dout_WIDTH  scaled, saturated or wrapped product
ovf  out  1  result not representable in dout_WIDTH; qualified by out_valid
occupancy  out  clog2(NUM_STAGE+1)  number of valid entries in the pipeline

Behaviour:
- Reset (ap_rst_n=0, async):
  - all stage valid bits, dout, ovf and occupancy are 0;
  - out_valid=0 immediately, without waiting for a clock edge;
  - in-flight data is discarded;
  - after deassertion, first accept is possible on the next rising edge.
- Transfer rules:
  - input transfer = in_valid & in_ready;
  - output transfer = out_valid & out_ready.
- Pipeline control:
  - global advance en = ~out_valid | out_ready;
  - in_ready = en (combinational from out_ready; no internal skid buffer);
  - when en=1 every stage shifts one position and stage 1 captures din0/din1 with valid = in_valid;
  - when en=0 all stages hold, and dout/ovf stay stable while out_valid=1.
- Latency and throughput:
  - result of an input accepted at edge t is presented with out_valid=1 after edge t+NUM_STAGE-1, provided en stayed 1;
  - each stall cycle adds one;
  - throughput is 1 per cycle when out_ready=1.
  - NUM_STAGE=1: single register stage; multiply and scale are combinational in front of it.
- Internal bubbles are not collapsed.
- occupancy = count of set stage valid bits:
  - +1 on input transfer without output transfer;
  - -1 on the reverse;
  - unchanged when both or neither occur.
- Arithmetic:
  - P = din0*din1 at full width W = din0_WIDTH + din1_WIDTH, signed when SIGNED=1;
  - R = (P + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT;
  - the shift is arithmetic when SIGNED=1;
  - the rounding add is done at W+1 bits, so it never overflows internally.
- Range check against dout range:
  - signed range is [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1];
  - unsigned range is [0, 2^dout_WIDTH-1].
  - R in range: dout = R, ovf=0.
  - R out of range, SAT=1: dout = nearest bound, ovf=1.
  - R out of range, SAT=0: dout = low dout_WIDTH bits of R, ovf=1.
  - If dout_WIDTH >= W-SHIFT+1 (signed) or >= W-SHIFT (unsigned), overflow is impossible and ovf is constant 0.
- Corner operands: most-negative x most-negative (signed) must be handled exactly; the full-width product never wraps.
- Internal split of multiply versus register stages is implementation choice; only end-to-end latency and handshake are specified.

Test Plan:
- Defaults, out_ready=1, din0=8191, din1=2047, one beat -> out_valid exactly 3 cycles after accept; dout=16766977, ovf=0, occupancy returns to 0.
- dout_WIDTH=8, SHIFT=4, ROUND=1, SAT=1, inputs (100,5), (-100,5), (-8192,-2048) back-to-back -> dout 31/ovf 0, then -31 (8'hE1)/ovf 0, then 127/ovf 1, on consecutive cycles.
- Same configuration with SAT=0, input (-8192,-2048) -> R=2^20, dout=8'h00, ovf=1.
- Defaults, out_ready=0, in_valid=1 for 5 cycles with distinct operands -> 3 accepted, then in_ready=0, occupancy=3, dout stable; release out_ready -> all 5 results in order, no drop or duplicate.
- Continuous in_valid=1, out_ready=1 for 20 beats -> one result per cycle, occupancy steady at 3.
- 2 beats in flight, pulse ap_rst_n low mid-cycle -> out_valid, occupancy and dout go 0 before the next edge; after release no stale result appears; a new beat completes with normal latency.
